// File: rtl/ll8_frame_padder_pkg.sv
// Shared defaults and state encoding for the LL8 short-frame padder.
package ll8_frame_padder_pkg;

    localparam int         DEF_MIN_LEN  = 60;
    localparam logic [7:0] DEF_PAD_BYTE = 8'h00;

    typedef enum logic {
        PASS = 1'b0,
        PAD  = 1'b1
    } pad_state_t;

endpackage

// File: rtl/ll8_frame_padder.sv
// LL8 frame padder: passes frames through with zero latency and appends pad
// bytes after a clean eof so that every good frame is at least MIN_LEN bytes.
module ll8_frame_padder
    import ll8_frame_padder_pkg::*;
#(
    parameter int         MIN_LEN  = DEF_MIN_LEN,
    parameter logic [7:0] PAD_BYTE = DEF_PAD_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [7:0] datain,
    input  logic       sof_i,
    input  logic       eof_i,
    input  logic       error_i,
    input  logic       src_rdy_i,
    output logic       dst_rdy_o,
    output logic [7:0] dataout,
    output logic       sof_o,
    output logic       eof_o,
    output logic       error_o,
    output logic       src_rdy_o,
    input  logic       dst_rdy_i
);

    localparam int              CNT_W    = $clog2(MIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_LEN - 1);

    pad_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             short_eof;
    logic             in_xfer;
    logic             out_xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // cnt + 1 < MIN_LEN is the same test as cnt < MIN_LEN - 1, without widening
    assign short_eof = eof_i & ~error_i & (cnt < CNT_LAST);
    assign in_xfer   = src_rdy_i & dst_rdy_o;
    assign out_xfer  = src_rdy_o & dst_rdy_i;

    always_comb begin
        dst_rdy_o = dst_rdy_i;
        src_rdy_o = src_rdy_i;
        dataout   = datain;
        sof_o     = sof_i;
        eof_o     = eof_i & ~short_eof;
        error_o   = error_i;
        if (state == PAD) begin
            dst_rdy_o = 1'b0;
            src_rdy_o = 1'b1;
            dataout   = PAD_BYTE;
            sof_o     = 1'b0;
            eof_o     = (cnt == CNT_LAST);
            error_o   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state <= PASS;
            cnt   <= '0;
        end else begin
            case (state)
                PASS: begin
                    if (in_xfer) begin
                        if (!eof_i) begin
                            cnt <= sat_inc(cnt);
                        end else if (short_eof) begin
                            cnt   <= cnt + CNT_W'(1);
                            state <= PAD;
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                PAD: begin
                    if (out_xfer) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= PASS;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= PASS;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ll8_frame_padder.sv
// Scoreboard bench for ll8_frame_padder: stimulus pushes expected output beats,
// a negedge monitor pops and compares on every output transfer.
module tb_ll8_frame_padder;

    localparam int MIN_LEN = 60;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
        logic       r;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] datain = 8'h00;
    logic       sof_i = 1'b0;
    logic       eof_i = 1'b0;
    logic       error_i = 1'b0;
    logic       src_rdy_i = 1'b0;
    logic       dst_rdy_o;
    logic [7:0] dataout;
    logic       sof_o;
    logic       eof_o;
    logic       error_o;
    logic       src_rdy_o;
    logic       dst_rdy_i = 1'b1;

    int    checks = 0;
    int    failures = 0;
    int    out_cnt = 0;
    int    cyc = 0;
    bit    rnd_mode = 1'b0;
    beat_t exp_q[$];
    beat_t prev_beat;
    bit    stall_prev = 1'b0;

    ll8_frame_padder #(.MIN_LEN(MIN_LEN), .PAD_BYTE(8'h00)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .datain(datain), .sof_i(sof_i), .eof_i(eof_i), .error_i(error_i),
        .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o),
        .dataout(dataout), .sof_o(sof_o), .eof_o(eof_o), .error_o(error_o),
        .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rnd_mode) begin
            #1 dst_rdy_i = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: outputs sampled on the falling edge, ahead of the transfer edge.
    always @(negedge clk) begin
        beat_t cur;
        beat_t exp;
        cur = '{d: dataout, s: sof_o, e: eof_o, r: error_o};
        if (!reset && !clear) begin
            if (stall_prev) begin
                checks++;
                if (cur != prev_beat) begin
                    failures++;
                    $display("FAIL stall_hold: got %h required %h", cur, prev_beat);
                end
            end
            if (src_rdy_o && dst_rdy_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_beat: got %h required none", cur);
                end else begin
                    exp = exp_q.pop_front();
                    if (cur != exp) begin
                        failures++;
                        $display("FAIL beat%0d: got d=%h s=%b e=%b r=%b required d=%h s=%b e=%b r=%b",
                                 out_cnt, cur.d, cur.s, cur.e, cur.r, exp.d, exp.s, exp.e, exp.r);
                    end
                end
                out_cnt++;
            end
            stall_prev = src_rdy_o && !dst_rdy_i && !dst_rdy_o;
            prev_beat  = cur;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e, input logic r);
        bit acc;
        bit done;
        datain = d; sof_i = s; eof_i = e; error_i = r; src_rdy_i = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            acc = dst_rdy_o && dst_rdy_i;
            @(posedge clk);
            #1;
            if (acc) done = 1'b1;
        end
        if (!done) begin
            failures++;
            checks++;
            $display("FAIL send_timeout: got no accept required accept of %h", d);
        end
    endtask

    // Push expectations for a frame starting at cnt=0, then drive it.
    task automatic send_frame(input int len, input logic [7:0] base, input logic err, input bit close);
        bit last;
        bit pad;
        pad = close && !err && (len < MIN_LEN);
        for (int i = 0; i < len; i++) begin
            last = close && (i == len - 1);
            exp_q.push_back('{d: base + 8'(i), s: (i == 0), e: last && !pad, r: last && err});
        end
        if (pad) begin
            for (int i = len; i < MIN_LEN; i++)
                exp_q.push_back('{d: 8'h00, s: 1'b0, e: (i == MIN_LEN - 1), r: 1'b0});
        end
        for (int i = 0; i < len; i++) begin
            last = close && (i == len - 1);
            send_byte(base + 8'(i), (i == 0), last, last && err);
        end
        src_rdy_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0; error_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int base_out;
        int base_cyc;

        // Reset and idle behaviour
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        sof_i = 1'b1; error_i = 1'b1; dst_rdy_i = 1'b0;
        #1;
        check("rst_src_rdy_o", src_rdy_o, 0);
        check("rst_dst_rdy_o_lo", dst_rdy_o, 0);
        check("rst_sof_follow", sof_o, 1);
        check("rst_err_follow", error_o, 1);
        dst_rdy_i = 1'b1; sof_i = 1'b0; error_i = 1'b0;
        #1;
        check("rst_dst_rdy_o_hi", dst_rdy_o, 1);
        check("rst_sof_follow0", sof_o, 0);
        @(posedge clk); #1;

        // 10-byte frame padded to 60
        base_out = out_cnt;
        send_frame(10, 8'h01, 1'b0, 1'b1);
        wait_drain("pad10");
        check("pad10_count", out_cnt - base_out, 60);

        // 60- and 100-byte frames back to back, no added cycles
        base_out = out_cnt;
        base_cyc = cyc;
        send_frame(60, 8'h10, 1'b0, 1'b1);
        send_frame(100, 8'h80, 1'b0, 1'b1);
        check("long_count", out_cnt - base_out, 160);
        check("long_cycles", cyc - base_cyc, 160);
        check("long_queue", exp_q.size(), 0);

        // 20-byte errored frame, then a normal frame from PASS
        base_out = out_cnt;
        send_frame(20, 8'h40, 1'b1, 1'b1);
        wait_drain("err20");
        check("err20_count", out_cnt - base_out, 20);
        check("err20_pass_state", dst_rdy_o, 1);
        send_frame(3, 8'h55, 1'b0, 1'b1);
        wait_drain("after_err");

        // 1-byte frame with random back-pressure
        rnd_mode = 1'b1;
        base_out = out_cnt;
        send_frame(1, 8'hAA, 1'b0, 1'b1);
        wait_drain("one_byte");
        rnd_mode = 1'b0;
        @(posedge clk); #2;
        dst_rdy_i = 1'b1;
        check("one_byte_count", out_cnt - base_out, 60);

        // Reset during padding after 30 bytes out
        base_out = out_cnt;
        send_frame(5, 8'h20, 1'b0, 1'b1);
        for (int k = 0; k < 200 && (out_cnt - base_out) < 30; k++) begin
            @(posedge clk); #1;
        end
        check("pre_reset_count", out_cnt - base_out, 30);
        check("pre_reset_in_pad", dst_rdy_o, 0);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_reset_src_rdy", src_rdy_o, 0);
        check("post_reset_dst_rdy", dst_rdy_o, 1);
        send_frame(60, 8'h30, 1'b0, 1'b1);
        wait_drain("post_reset60");

        // Clear mid-frame at byte 5, then a 10-byte frame pads to 60
        send_frame(5, 8'h60, 1'b0, 1'b0);
        wait_drain("partial5");
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        base_out = out_cnt;
        send_frame(10, 8'h70, 1'b0, 1'b1);
        wait_drain("clear10");
        check("clear10_count", out_cnt - base_out, 60);

        repeat (3) @(posedge clk);
        #1;
        check("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ll8_frame_padder.md
LL8_FRAME_PADDER -- requirements
Module: ll8_frame_padder

Interface
REQ-001 Parameter MIN_LEN, default 60, minimum emitted frame length in bytes (Ethernet minimum excluding CRC); legal range 2..255.
REQ-002 Parameter PAD_BYTE, default 8'h00, value emitted for each pad byte.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clear  input  1  synchronous, active-high flush, same effect as reset.
REQ-006 datain  input  8  LL8 input byte.
REQ-007 sof_i / eof_i / error_i  input  1 each  start-of-frame, end-of-frame and error flags for datain.
REQ-008 src_rdy_i  input  1  upstream byte valid.
REQ-009 dst_rdy_o  output  1  block accepts the input byte.
REQ-010 dataout  output  8  LL8 output byte.
REQ-011 sof_o / eof_o / error_o  output  1 each  output frame flags.
REQ-012 src_rdy_o  output  1  output byte valid.
REQ-013 dst_rdy_i  input  1  downstream accepts the output byte.

Function
REQ-014 A transfer occurs on a port when src_rdy and dst_rdy are both high on a rising edge; no other condition moves data.
REQ-015 The block has two states, PASS and PAD, plus a byte counter cnt saturating at MIN_LEN, sized $clog2(MIN_LEN+1) bits.
REQ-016 In PASS, the datapath is combinational with zero latency: dataout=datain, sof_o=sof_i, error_o=error_i, src_rdy_o=src_rdy_i, dst_rdy_o=dst_rdy_i.
REQ-017 In PASS, eof_o=eof_i except when eof_i=1, error_i=0 and cnt+1<MIN_LEN, in which case eof_o=0.
REQ-018 In PASS, each input transfer without eof_i increments cnt (saturating); a transfer with eof_i and no padding required sets cnt=0 and stays in PASS.
REQ-019 In PASS, a transfer with eof_i=1, error_i=0 and cnt+1<MIN_LEN sets cnt=cnt+1 and enters PAD.
REQ-020 Errored frames (eof_i with error_i=1) are never padded; eof and error pass through unchanged.
REQ-021 In PAD: dst_rdy_o=0, src_rdy_o=1, dataout=PAD_BYTE, sof_o=0, error_o=0, eof_o=(cnt==MIN_LEN-1).
REQ-022 In PAD, each output transfer increments cnt; the transfer with eof_o=1 sets cnt=0 and returns to PASS.
REQ-023 Frames of length >= MIN_LEN pass bit-exact with no added bytes and no added cycles.
REQ-024 sof_i is not used to reset cnt; frame boundaries are defined solely by eof transfers (a missing sof is passed through, not repaired).
REQ-025 A one-byte frame (sof_i=eof_i=1) emits sof_o=1, eof_o=0 on that byte followed by MIN_LEN-1 pad bytes.
REQ-026 Back-pressure (dst_rdy_i=0) in PAD holds dataout and all flags stable and cnt unchanged.

Reset
REQ-027 On reset or clear: state=PASS, cnt=0 on the next edge, regardless of state or pending transfer; any partial frame or padding in progress is abandoned.
REQ-028 During reset or clear, input transfers are ignored and cnt does not advance.
REQ-029 After reset with src_rdy_i=0, src_rdy_o=0, dst_rdy_o=dst_rdy_i and all flag outputs follow inputs (PASS state).

Structure
REQ-030 A shared package holds the default MIN_LEN (60), the default PAD_BYTE (8'h00) and the PASS/PAD state encoding.
REQ-031 The block is a single module with no sub-modules; it sits directly upstream of ll8_shortfifo in the TX path, feeding the FIFO's LL8 input.

Verification
REQ-032 10-byte frame 0x01..0x0A, no stalls -> 60 output bytes: 0x01..0x0A then 50 x 0x00, sof_o on byte 1, eof_o only on byte 60, error_o=0.
REQ-033 60-byte and 100-byte frames back-to-back -> outputs identical to inputs, zero added cycles, cnt=0 after each eof.
REQ-034 20-byte frame with error_i=1 on eof -> exactly 20 bytes out, eof_o=error_o=1 on byte 20, no padding, next frame starts in PASS.
REQ-035 1-byte frame 0xAA with random dst_rdy_i toggling -> 0xAA with sof_o=1, eof_o=0, then 59 x 0x00, eof on the 59th pad; outputs stable while stalled.
REQ-036 Reset asserted during PAD after 30 bytes emitted -> next cycle src_rdy_o follows src_rdy_i, a following 60-byte frame passes unchanged.
REQ-037 clear asserted during PASS mid-frame at byte 5, then 10-byte frame -> 60-byte padded output (count restarted at 0).
